neuron: RTL and testbench

NEURON -- requirements
Module: neuron

---
 rtl/neuron.sv | 122 ++++++++++++
 tb/tb_neuron.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron.sv
// Pipelined multiply-accumulate neuron: dot product, adder tree, shift, bias add and saturation.
// Define NEURON_RELU_EN to clamp negative results to zero in the output stage.
package cnn1d_pkg;
  localparam int DATA_WIDTH = 16;
endpackage

module neuron #(
  parameter int NUM_INPUTS = 1,
  parameter int DATA_WIDTH = cnn1d_pkg::DATA_WIDTH,
  parameter int FRAC_BITS  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         neuron_ready_in,
  input  logic                         neuron_valid_in,
  input  logic signed [DATA_WIDTH-1:0] neuron_data_in [0:NUM_INPUTS-1],
  input  logic signed [DATA_WIDTH-1:0] neuron_weights [0:NUM_INPUTS-1],
  input  logic signed [DATA_WIDTH-1:0] neuron_bias,
  input  logic                         neuron_ready_out,
  output logic                         neuron_valid_out,
  output logic signed [DATA_WIDTH-1:0] neuron_data_out
);

  localparam int K      = $clog2(NUM_INPUTS);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int SUM_W  = PROD_W + K + 1;
  localparam int HALF_N = (NUM_INPUTS + 1) / 2;

  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  // Number of live operands at a given tree level (level 0 holds the products).
  function automatic int level_count(input int lv);
    return (NUM_INPUTS + (1 << lv) - 1) >> lv;
  endfunction

  function automatic int pair_hi(input int j);
    return (2 * j + 1 < NUM_INPUTS) ? 2 * j + 1 : 2 * j;
  endfunction

  logic signed [SUM_W-1:0]      tree        [0:K][0:NUM_INPUTS-1];
  logic signed [DATA_WIDTH-1:0] stage_bias  [0:K];
  logic        [K:0]            stage_valid;
  logic signed [PROD_W-1:0]     product     [0:NUM_INPUTS-1];
  logic signed [SUM_W-1:0]      shifted;
  logic signed [SUM_W-1:0]      biased;
  logic signed [DATA_WIDTH-1:0] saturated;
  logic signed [DATA_WIDTH-1:0] activated;
  logic                         enable;

  assign enable          = !neuron_valid_out || neuron_ready_out;
  assign neuron_ready_in = enable && !rst;

  // Operands are sign-extended to full product width so the multiply is exact.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      product[i] = $signed(
        {{DATA_WIDTH{neuron_data_in[i][DATA_WIDTH-1]}}, neuron_data_in[i]} *
        {{DATA_WIDTH{neuron_weights[i][DATA_WIDTH-1]}}, neuron_weights[i]});
    end
  end

  always_comb begin
    shifted   = tree[K][0] >>> FRAC_BITS;
    biased    = shifted + $signed({{(SUM_W - DATA_WIDTH){stage_bias[K][DATA_WIDTH-1]}},
                                   stage_bias[K]});
    saturated = biased[DATA_WIDTH-1:0];
    if (biased > SAT_MAX) begin
      saturated = SAT_MAX[DATA_WIDTH-1:0];
    end else if (biased < SAT_MIN) begin
      saturated = SAT_MIN[DATA_WIDTH-1:0];
    end
`ifdef NEURON_RELU_EN
    activated = saturated[DATA_WIDTH-1] ? '0 : saturated;
`else
    activated = saturated;
`endif
  end

  // The whole pipeline shares one enable, so a downstream stall freezes every stage at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid      <= '0;
      neuron_valid_out <= 1'b0;
      neuron_data_out  <= '0;
      for (int lv = 0; lv <= K; lv++) begin
        stage_bias[lv] <= '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
          tree[lv][j] <= '0;
        end
      end
    end else if (enable) begin
      stage_valid[0] <= neuron_valid_in;
      if (neuron_valid_in) begin
        stage_bias[0] <= neuron_bias;
        for (int i = 0; i < NUM_INPUTS; i++) begin
          tree[0][i] <= {{(SUM_W - PROD_W){product[i][PROD_W-1]}}, product[i]};
        end
      end
      for (int lv = 1; lv <= K; lv++) begin
        stage_valid[lv] <= stage_valid[lv-1];
        stage_bias[lv]  <= stage_bias[lv-1];
        for (int j = 0; j < HALF_N; j++) begin
          if (2 * j + 1 < level_count(lv - 1)) begin
            tree[lv][j] <= tree[lv-1][2*j] + tree[lv-1][pair_hi(j)];
          end else if (2 * j < level_count(lv - 1)) begin
            tree[lv][j] <= tree[lv-1][2*j];
          end else begin
            tree[lv][j] <= '0;
          end
        end
      end
      neuron_valid_out <= stage_valid[K];
      if (stage_valid[K]) begin
        neuron_data_out <= activated;
      end
    end
  end

endmodule

// File: tb/tb_neuron.sv
// Directed self-checking bench for neuron: three instances (1, 4 and 3 inputs, the last with FRAC_BITS=2).
// Expected values are hand-computed pre-activation results; NEURON_RELU_EN applies the clamp.
module tb_neuron;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic               v1_in, r1_out, rdy1_in, v1_out;
  logic signed [15:0] d1 [0:0];
  logic signed [15:0] w1 [0:0];
  logic signed [15:0] b1, q1;

  logic               v4_in, r4_out, rdy4_in, v4_out;
  logic signed [15:0] d4 [0:3];
  logic signed [15:0] w4 [0:3];
  logic signed [15:0] b4, q4;

  logic               v3_in, r3_out, rdy3_in, v3_out;
  logic signed [15:0] d3 [0:2];
  logic signed [15:0] w3 [0:2];
  logic signed [15:0] b3, q3;

  neuron #(.NUM_INPUTS(1), .DATA_WIDTH(16), .FRAC_BITS(0)) dut1 (
    .clk(clk), .rst(rst), .neuron_ready_in(rdy1_in), .neuron_valid_in(v1_in),
    .neuron_data_in(d1), .neuron_weights(w1), .neuron_bias(b1),
    .neuron_ready_out(r1_out), .neuron_valid_out(v1_out), .neuron_data_out(q1));

  neuron #(.NUM_INPUTS(4), .DATA_WIDTH(16), .FRAC_BITS(0)) dut4 (
    .clk(clk), .rst(rst), .neuron_ready_in(rdy4_in), .neuron_valid_in(v4_in),
    .neuron_data_in(d4), .neuron_weights(w4), .neuron_bias(b4),
    .neuron_ready_out(r4_out), .neuron_valid_out(v4_out), .neuron_data_out(q4));

  neuron #(.NUM_INPUTS(3), .DATA_WIDTH(16), .FRAC_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .neuron_ready_in(rdy3_in), .neuron_valid_in(v3_in),
    .neuron_data_in(d3), .neuron_weights(w3), .neuron_bias(b3),
    .neuron_ready_out(r3_out), .neuron_valid_out(v3_out), .neuron_data_out(q3));

  // {data, weight, bias, expected}
  int t1 [6][4] = '{
    '{5, -5, 5, -20},
    '{32767, 32767, 0, 32767},
    '{32767, -32768, 0, -32768},
    '{100, 3, -7, 293},
    '{-200, 200, 0, -32768},
    '{-1, -1, 32767, 32767}};

  // {d0..d3, w0..w3, bias, expected}
  int t4 [5][10] = '{
    '{1, 2, 3, 4, 1, 1, 1, 1, 10, 20},
    '{-3, 7, 100, -50, 2, -4, 3, 6, -1, -35},
    '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 0, 32767},
    '{-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767, 0, -32768},
    '{-32768, -32768, -32768, -32768, -32768, -32768, 32767, 32767, -32768, 32767}};

  // {d0..d2, w0..w2, bias, expected} with a 2-bit arithmetic right shift before the bias
  int t3 [5][8] = '{
    '{3, 5, -7, 1, 2, 1, 1, 2},
    '{-3, 1, 0, 1, 0, 5, 0, -1},
    '{0, 0, 100, 0, 0, 4, -5, 95},
    '{32767, 32767, 32767, 32767, 32767, 32767, 0, 32767},
    '{-32768, -32768, -32768, 32767, 32767, 32767, 100, -32768}};

  function automatic int relu(input int x);
`ifdef NEURON_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (v1_out !== 1'b0 || q1 !== 16'sd0 || rdy1_in !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut1: valid=%b data=%0d ready_in=%b, expected 0/0/0", v1_out, q1, rdy1_in);
    end
    checks++;
    if (v4_out !== 1'b0 || q4 !== 16'sd0 || rdy4_in !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut4: valid=%b data=%0d ready_in=%b, expected 0/0/0", v4_out, q4, rdy4_in);
    end
    checks++;
    if (v3_out !== 1'b0 || q3 !== 16'sd0 || rdy3_in !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut3: valid=%b data=%0d ready_in=%b, expected 0/0/0", v3_out, q3, rdy3_in);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (rdy1_in !== 1'b1 || rdy4_in !== 1'b1 || rdy3_in !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset: got %b%b%b, expected 111", rdy1_in, rdy4_in, rdy3_in);
    end
    r1_out = 1'b1;
    r4_out = 1'b1;
    r3_out = 1'b1;
  endtask

  task automatic run1(input int idx);
    int n = 0;
    bit seen = 1'b0;
    @(posedge clk);
    #1;
    d1[0] = 16'(t1[idx][0]);
    w1[0] = 16'(t1[idx][1]);
    b1    = 16'(t1[idx][2]);
    v1_in = 1'b1;
    while (!seen && n < 10) begin
      @(posedge clk);
      n++;
      #1 v1_in = 1'b0;
      @(negedge clk);
      seen = v1_out;
    end
    checks++;
    if (!seen || n != 2) begin
      errors++;
      $display("[TB] FAIL latency1[%0d]: got %0d cycles (seen=%b), expected 2", idx, n, seen);
    end
    checks++;
    if (q1 !== 16'(relu(t1[idx][3]))) begin
      errors++;
      $display("[TB] FAIL single[%0d]: got %0d, expected %0d", idx, q1, relu(t1[idx][3]));
    end
  endtask

  task automatic run4(input int idx);
    int n = 0;
    bit seen = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      d4[i] = 16'(t4[idx][i]);
      w4[i] = 16'(t4[idx][4+i]);
    end
    b4    = 16'(t4[idx][8]);
    v4_in = 1'b1;
    while (!seen && n < 10) begin
      @(posedge clk);
      n++;
      #1 v4_in = 1'b0;
      @(negedge clk);
      seen = v4_out;
    end
    checks++;
    if (!seen || n != 4) begin
      errors++;
      $display("[TB] FAIL latency4[%0d]: got %0d cycles (seen=%b), expected 4", idx, n, seen);
    end
    checks++;
    if (q4 !== 16'(relu(t4[idx][9]))) begin
      errors++;
      $display("[TB] FAIL sum4[%0d]: got %0d, expected %0d", idx, q4, relu(t4[idx][9]));
    end
  endtask

  task automatic run3(input int idx);
    int n = 0;
    bit seen = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      d3[i] = 16'(t3[idx][i]);
      w3[i] = 16'(t3[idx][3+i]);
    end
    b3    = 16'(t3[idx][6]);
    v3_in = 1'b1;
    while (!seen && n < 10) begin
      @(posedge clk);
      n++;
      #1 v3_in = 1'b0;
      @(negedge clk);
      seen = v3_out;
    end
    checks++;
    if (!seen || n != 4) begin
      errors++;
      $display("[TB] FAIL latency3[%0d]: got %0d cycles (seen=%b), expected 4", idx, n, seen);
    end
    checks++;
    if (q3 !== 16'(relu(t3[idx][7]))) begin
      errors++;
      $display("[TB] FAIL odd_frac[%0d]: got %0d, expected %0d", idx, q3, relu(t3[idx][7]));
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 6; i++) run1(i);
  endtask

  task automatic test_sum4();
    for (int i = 0; i < 5; i++) run4(i);
  endtask

  task automatic test_odd_frac();
    for (int i = 0; i < 5; i++) run3(i);
  endtask

  // Beat k: data {k..k+3}, weights {1,-1,2,3}, bias k, result 6k+12.
  task automatic drive_ramp(input int k);
    for (int i = 0; i < 4; i++) d4[i] = 16'(k + i);
    w4[0] = 16'sd1;
    w4[1] = -16'sd1;
    w4[2] = 16'sd2;
    w4[3] = 16'sd3;
    b4    = 16'(k);
    v4_in = 1'b1;
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int first_n = -1;
    int last_n = -1;
    @(posedge clk);
    #1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          drive_ramp(k);
          @(posedge clk);
          #1;
        end
        v4_in = 1'b0;
      end
      begin
        for (int n = 1; n <= 14; n++) begin
          @(posedge clk);
          @(negedge clk);
          if (v4_out) begin
            if (got == 0) first_n = n;
            last_n = n;
            if (got < 6) begin
              checks++;
              if (q4 !== 16'(6 * got + 12)) begin
                errors++;
                $display("[TB] FAIL stream[%0d]: got %0d, expected %0d", got, q4, 6 * got + 12);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 6 || first_n != 4 || last_n != 9) begin
      errors++;
      $display("[TB] FAIL stream_timing: beats=%0d first=%0d last=%0d, expected 6/4/9", got, first_n, last_n);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    int got = 0;
    bit stable = 1'b1;
    r4_out = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 10; k < 13; k++) begin
      drive_ramp(k);
      @(posedge clk);
      #1;
    end
    v4_in = 1'b0;
    while (!v4_out && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (v4_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_fill: valid_out=%b after %0d cycles, expected 1", v4_out, n);
    end
    for (int i = 0; i < 4; i++) d4[i] = 16'sd1000;
    v4_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (v4_out !== 1'b1 || q4 !== 16'sd72 || rdy4_in !== 1'b0) stable = 1'b0;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("[TB] FAIL stall_hold: valid=%b data=%0d ready_in=%b, expected 1/72/0", v4_out, q4, rdy4_in);
    end
    v4_in  = 1'b0;
    r4_out = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (v4_out) begin
        if (got < 3) begin
          checks++;
          if (q4 !== 16'(6 * (got + 10) + 12)) begin
            errors++;
            $display("[TB] FAIL resume[%0d]: got %0d, expected %0d", got, q4, 6 * (got + 10) + 12);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (got != 3) begin
      errors++;
      $display("[TB] FAIL resume_count: got %0d beats, expected 3", got);
    end
  endtask

  task automatic test_reset_inflight();
    bit leaked = 1'b0;
    @(posedge clk);
    #1;
    drive_ramp(1);
    @(posedge clk);
    #1 v4_in = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (v4_out !== 1'b0 || q4 !== 16'sd0 || rdy4_in !== 1'b0 || q1 !== 16'sd0) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b data4=%0d ready_in=%b data1=%0d, expected 0/0/0/0",
               v4_out, q4, rdy4_in, q1);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (v4_out) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      errors++;
      $display("[TB] FAIL flush: in-flight beat reached output after reset, expected none");
    end
    run4(0);
  endtask

  initial begin
    v1_in = 1'b0; r1_out = 1'b0; d1[0] = '0; w1[0] = '0; b1 = '0;
    v4_in = 1'b0; r4_out = 1'b0; b4 = '0;
    v3_in = 1'b0; r3_out = 1'b0; b3 = '0;
    for (int i = 0; i < 4; i++) begin
      d4[i] = '0;
      w4[i] = '0;
    end
    for (int i = 0; i < 3; i++) begin
      d3[i] = '0;
      w3[i] = '0;
    end
    test_reset();
    test_single();
    test_sum4();
    test_odd_frac();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
